// File: rtl/sobel_job_sequencer.sv
// sobel_job_sequencer: top-level job FSM for the SD-card Sobel edge-detection flow.
// Runs the SD init table with per-command retry, loads the header and pixels into the
// Image Receiver, drives the SED, then streams the stored results back to the card.
// Optional feature macro: SOBEL_PIXCOUNT_EN (adds pix_count output and err_code 3).
module sobel_job_sequencer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       HDR_BYTES = 54,
  parameter int unsigned       PIX_BYTES = 3,
  parameter logic [ADDR_W-1:0] SRAM_BASE = ADDR_W'(54),
  parameter int unsigned       MAX_RETRY = 3,
  parameter int unsigned       TIMEOUT   = 65535
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              detect,
  input  logic              hold,
  input  logic              sd_error,
  input  logic              enable,
  input  logic              eof,
  input  logic              buffer_full,
  input  logic              new_col,
  input  logic              sed_done,
  input  logic [31:0]       img_size,
  input  logic [ADDR_W-1:0] w_address,
  output logic              sd_cmd_req,
  output logic [5:0]        sd_cmd_idx,
  output logic              sd_read,
  output logic              sd_write,
  output logic              sd_change_size,
  output logic [31:0]       sd_block_size,
  output logic              read_header,
  output logic              read_buffer,
  output logic              sed_en,
  output logic              sram_write,
  output logic              sram_read,
  output logic [ADDR_W-1:0] sram_address,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
`ifdef SOBEL_PIXCOUNT_EN
  ,
  output logic [31:0]       pix_count
`endif
);

  localparam int unsigned STEP_W  = 3;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);

  localparam logic [STEP_W-1:0]  LAST_STEP = STEP_W'(5);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]    WD_MAX    = WD_W'(TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE, S_INIT, S_INIT_GAP, S_SET_HDR, S_RD_HDR_CMD, S_RD_HDR, S_WR_HDR,
    S_SET_PIX, S_CHECK_EOF, S_RD_PIX_CMD, S_RD_PIX, S_SED, S_STORE,
    S_SET_WR, S_WR_CHK, S_WR_FETCH, S_WR_SEND, S_FAIL, S_FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         blk_d;
  logic [1:0]          err_d;
  logic                watched, progress;
  logic                req_d, read_d, write_d, chg_d, hdr_d, buf_d;
  logic                sed_d, sw_d, sr_d, done_d, error_d;
  logic [5:0]          idx_d;

  // SD init command table
  function automatic logic [5:0] cmd_idx(input logic [STEP_W-1:0] s);
    case (s)
      3'd0:    cmd_idx = 6'd0;
      3'd1:    cmd_idx = 6'd8;
      3'd2:    cmd_idx = 6'd41;
      3'd3:    cmd_idx = 6'd2;
      3'd4:    cmd_idx = 6'd3;
      3'd5:    cmd_idx = 6'd7;
      default: cmd_idx = 6'd0;
    endcase
  endfunction

  // Next state, watchdog, register updates and strobe decode of the next state
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    retry_d  = retry_q;
    end_d    = end_q;
    addr_d   = sram_address;
    blk_d    = sd_block_size;
    err_d    = err_code;
    watched  = 1'b0;
    progress = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (detect) begin
          state_d = S_INIT;
          step_d  = '0;
          retry_d = '0;
        end
      end
      S_INIT: begin
        watched = 1'b1;
        if (!hold) begin
          progress = 1'b1;
          if (!sd_error) begin
            retry_d = '0;
            if (step_q == LAST_STEP) state_d = S_SET_HDR;
            else                     step_d  = step_q + STEP_W'(1);
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_INIT_GAP;
          end else begin
            state_d = S_FAIL;
            err_d   = 2'd1;
          end
        end
      end
      S_INIT_GAP: state_d = S_INIT;
      S_SET_HDR: begin
        watched = 1'b1;
        if (!hold) state_d = S_RD_HDR_CMD;
      end
      S_RD_HDR_CMD: begin
        watched = 1'b1;
        if (enable) state_d = S_RD_HDR;
      end
      S_RD_HDR: begin
        watched = 1'b1;
        if (!hold) state_d = S_WR_HDR;
      end
      S_WR_HDR: begin
        watched = 1'b1;
        if (!hold) state_d = S_SET_PIX;
      end
      S_SET_PIX: begin
        watched = 1'b1;
        if (!hold) state_d = S_CHECK_EOF;
      end
      S_CHECK_EOF: state_d = eof ? S_SET_WR : S_RD_PIX_CMD;
      S_RD_PIX_CMD: begin
        watched = 1'b1;
        if (enable) state_d = S_RD_PIX;
      end
      S_RD_PIX: begin
        watched = 1'b1;
        if (!hold) state_d = (new_col && !buffer_full) ? S_RD_PIX_CMD : S_SED;
      end
      S_SED: begin
        watched = 1'b1;
        if (sed_done) state_d = S_STORE;
      end
      S_STORE: state_d = S_CHECK_EOF;
      S_SET_WR: begin
        watched = 1'b1;
`ifdef SOBEL_PIXCOUNT_EN
        if (pix_count == 32'd0) begin
          state_d = S_FAIL;
          err_d   = 2'd3;
        end else if (!hold) begin
          state_d = S_WR_CHK;
        end
`else
        if (!hold) state_d = S_WR_CHK;
`endif
      end
      S_WR_CHK:   state_d = (sram_address == end_q) ? S_FINISH : S_WR_FETCH;
      S_WR_FETCH: state_d = S_WR_SEND;
      S_WR_SEND: begin
        watched = 1'b1;
        if (!hold) begin
          addr_d  = sram_address + ADDR_W'(1);
          state_d = S_WR_CHK;
        end
      end
      S_FAIL:   state_d = S_FAIL;
      S_FINISH: err_d   = 2'd0;
      default:  state_d = S_IDLE;
    endcase

    // Watchdog only fires when the cycle made no forward progress
    if (watched && !progress && (state_d == state_q) && (wdog_q >= WD_LAST)) begin
      state_d = S_FAIL;
      err_d   = 2'd2;
    end

    if (state_d != state_q)                 wdog_d = '0;
    else if (watched && (wdog_q != WD_MAX)) wdog_d = wdog_q + WD_W'(1);
    else                                    wdog_d = wdog_q;

    // Size/address registers load on entry so they are valid alongside their strobes
    case (state_d)
      S_SET_HDR: blk_d = 32'(HDR_BYTES);
      S_SET_PIX: blk_d = 32'(PIX_BYTES);
      S_SET_WR: begin
        blk_d  = img_size;
        addr_d = SRAM_BASE;
      end
      S_STORE: begin
        addr_d = w_address;
        end_d  = w_address + ADDR_W'(1);
      end
      default: ;
    endcase

    req_d   = (state_d == S_INIT);
    idx_d   = (state_d == S_INIT) ? cmd_idx(step_d) : 6'd0;
    read_d  = (state_d == S_RD_HDR_CMD) || (state_d == S_RD_PIX_CMD);
    write_d = (state_d == S_WR_HDR) || (state_d == S_WR_SEND);
    chg_d   = (state_d == S_SET_HDR) || (state_d == S_SET_PIX) || (state_d == S_SET_WR);
    hdr_d   = (state_d == S_RD_HDR);
    buf_d   = (state_d == S_RD_PIX);
    sed_d   = (state_d == S_SED);
    sw_d    = (state_d == S_STORE);
    sr_d    = (state_d == S_WR_FETCH);
    done_d  = (state_d == S_FAIL) || (state_d == S_FINISH);
    error_d = (state_d == S_FAIL);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      step_q         <= '0;
      retry_q        <= '0;
      wdog_q         <= '0;
      end_q          <= SRAM_BASE;
      sram_address   <= SRAM_BASE;
      sd_block_size  <= '0;
      err_code       <= '0;
      sd_cmd_req     <= 1'b0;
      sd_cmd_idx     <= '0;
      sd_read        <= 1'b0;
      sd_write       <= 1'b0;
      sd_change_size <= 1'b0;
      read_header    <= 1'b0;
      read_buffer    <= 1'b0;
      sed_en         <= 1'b0;
      sram_write     <= 1'b0;
      sram_read      <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      retry_q        <= retry_d;
      wdog_q         <= wdog_d;
      end_q          <= end_d;
      sram_address   <= addr_d;
      sd_block_size  <= blk_d;
      err_code       <= err_d;
      sd_cmd_req     <= req_d;
      sd_cmd_idx     <= idx_d;
      sd_read        <= read_d;
      sd_write       <= write_d;
      sd_change_size <= chg_d;
      read_header    <= hdr_d;
      read_buffer    <= buf_d;
      sed_en         <= sed_d;
      sram_write     <= sw_d;
      sram_read      <= sr_d;
      done           <= done_d;
      error          <= error_d;
    end
  end

`ifdef SOBEL_PIXCOUNT_EN
  // Saturating count of stored SED results
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                      pix_count <= '0;
    else if ((state_q == S_STORE) && (pix_count != '1)) pix_count <= pix_count + 32'd1;
  end
`endif

endmodule

// File: doc/sobel_job_sequencer.md
Name: sobel_job_sequencer

Overview:
- Parametrised, second-generation top-level FSM for the SD-card Sobel edge-detection flow.
- Runs the SD init command table with per-command retry, then reads the header and pixel data into the Image Receiver.
- Sequences the Sobel engine and streams the SRAM result buffer back to the card.
- Adds retry, a watchdog timeout, an error code, a registered block size and a bounded write-out range; sits between the SD Interface, the Image Receiver, the SED and the SRAM FIFO.

Parameters:
- ADDR_W, 16, SRAM address width.
- HDR_BYTES, 54, header block size in bytes.
- PIX_BYTES, 3, pixel read block size in bytes.
- SRAM_BASE, 54, first result address (ADDR_W bits).
- MAX_RETRY, 3, re-issues allowed per init command after an sd_error.
- TIMEOUT, 65535, watchdog limit in cycles (counter width is clog2(TIMEOUT+1)).

Ports:
- clk, input, 1, clock.
- n_rst, input, 1, asynchronous active-low reset.
- detect, input, 1, card present; starts a job.
- hold, input, 1, SD Interface busy; low means the current command is complete.
- sd_error, input, 1, SD command error; sampled only when hold is low.
- enable, input, 1, SD data ready for the Image Receiver.
- eof, input, 1, Image Receiver has finished the file.
- buffer_full, input, 1, Image Receiver window is full.
- new_col, input, 1, Image Receiver is on a new column.
- sed_done, input, 1, SED result is valid.
- img_size, input, 32, write-out block size in bytes.
- w_address, input, ADDR_W, SRAM address for the current SED result.
- sd_cmd_req, output, 1, init command request.
- sd_cmd_idx, output, 6, init command index.
- sd_read, output, 1, SD read command.
- sd_write, output, 1, SD write command.
- sd_change_size, output, 1, SD change block size command.
- sd_block_size, output, 32, registered block size.
- read_header, output, 1, Image Receiver header enable.
- read_buffer, output, 1, Image Receiver pixel enable.
- sed_en, output, 1, SED enable.
- sram_write, output, 1, write a result into the FIFO.
- sram_read, output, 1, read a word from the FIFO.
- sram_address, output, ADDR_W, SRAM address.
- done, output, 1, job finished (success or failure).
- error, output, 1, job failed.
- err_code, output, 2, failure cause.

Behaviour:
- Reset (async): state IDLE.
  - All strobes 0; sd_block_size 0; sram_address SRAM_BASE.
  - err_code 0; retry, step and watchdog counters 0; end_addr SRAM_BASE.
- Strobes are Moore outputs decoded from the state.
- sd_block_size, sram_address, err_code and end_addr are registers.
- IDLE: detect=1 -> INIT, step=0.
- INIT: sd_cmd_req=1; sd_cmd_idx = table[step], table = 0, 8, 41, 2, 3, 7.
  - hold=0 and sd_error=0: step+1, retry=0; after step 5 -> SET_HDR.
  - hold=0 and sd_error=1 and retry<MAX_RETRY: retry+1, go to INIT_GAP for 1 cycle (sd_cmd_req=0), then back to INIT with the same step.
  - hold=0 and sd_error=1 and retry==MAX_RETRY: FAIL, err_code=1.
- SET_HDR: sd_change_size=1, sd_block_size<=HDR_BYTES; hold=0 -> RD_HDR_CMD.
- RD_HDR_CMD: sd_read=1; enable=1 -> RD_HDR.
- RD_HDR: read_header=1; hold=0 -> WR_HDR.
- WR_HDR: sd_write=1; hold=0 -> SET_PIX.
- SET_PIX: sd_change_size=1, sd_block_size<=PIX_BYTES; hold=0 -> CHECK_EOF.
- CHECK_EOF: 1 cycle.
  - eof=1 -> SET_WR.
  - eof=0 -> RD_PIX_CMD.
- RD_PIX_CMD: sd_read=1; enable=1 -> RD_PIX.
- RD_PIX: read_buffer=1; on hold=0:
  - new_col=1 and buffer_full=0 -> RD_PIX_CMD.
  - otherwise -> SED.
- SED: sed_en=1; sed_done=1 -> STORE.
- STORE: 1 cycle; sram_write=1; sram_address<=w_address; end_addr<=w_address+1 (mod 2^ADDR_W); -> CHECK_EOF.
- SET_WR: sd_change_size=1, sd_block_size<=img_size, sram_address<=SRAM_BASE; hold=0 -> WR_CHK.
- WR_CHK:
  - sram_address==end_addr -> FINISH.
  - Otherwise -> WR_FETCH.
  - No result stored means zero words are written.
- WR_FETCH: 1 cycle; sram_read=1 -> WR_SEND.
- WR_SEND: sd_write=1; hold=0 -> sram_address+1 (wraps 2^ADDR_W-1 -> 0), -> WR_CHK.
- Watchdog covers INIT, SET_*, RD_*, WR_HDR, SED and WR_SEND.
  - It counts every cycle spent in those states and clears on any state change.
  - Reaching TIMEOUT -> FAIL, err_code=2.
  - A hold=0 completion on the same cycle wins over the timeout.
- FAIL: done=1, error=1; stays until reset.
- FINISH: done=1, error=0, err_code=0; stays until reset.
- Reset mid-job returns everything to the reset values on the next edge; no partial command is held.
- detect deassertion after start is ignored.

Optional Feature:
- Macro: SOBEL_PIXCOUNT_EN.
- When defined, adds output pix_count (32 bits).
  - Reset to 0; increments on every STORE cycle; saturates at 2^32-1; held through FINISH and FAIL.
  - Also adds err_code=3: in SET_WR, a pix_count of 0 -> FAIL instead of writing.
- When not defined: no port, no counter, and err_code 3 is never produced.

Test Plan:
- Clean init: detect=1, each command completes with hold low for 1 cycle -> sd_cmd_idx sequence 0, 8, 41, 2, 3, 7, then sd_change_size with sd_block_size=54.
- Retry: sd_error on the first two CMD8 completions -> CMD8 is issued 3 times with a 1-cycle gap and the flow continues. With MAX_RETRY=1, the same stimulus -> done=1, error=1, err_code=1.
- Timeout (TIMEOUT=100): hold stuck high in RD_PIX -> FAIL after 100 cycles, err_code=2. Releasing hold on cycle 100 -> no failure.
- Pixel loop: 4 pixels, w_address 54..57, eof raised after the last one -> 4 sram_write pulses, then sd_block_size=img_size, then 4 sram_read/sd_write pairs at addresses 54..57, then done=1, error=0.
- Wrap (ADDR_W=4, SRAM_BASE=14): w_address 14, 15, 0 -> write-out addresses 14, 15, 0, stopping at end_addr=1.
- Immediate eof with SOBEL_PIXCOUNT_EN defined -> err_code=3. Without the macro -> zero writes, then FINISH.
